ram_init_sequencer: RTL and testbench
=====================================

Name: ram_init_sequencer

Overview:
- Sits directly downstream of the reset controller.
- Consumes the one-cycle reset-start pulse (initStart) and the reset-sequence level (seqActive).
- Sweeps every entry of a RAM-backed table (physical register free list, rename map, predictor tables), writing an initial pattern one entry per cycle.
- Once the sweep completes, passes normal write requests through to the same RAM write port, so each table needs only this block in front of it.

Parameters:
NUM_ENTRIES, 64, number of RAM entries to initialize; must be >= 2.
DATA_W, 8, RAM data width in bits.
INIT_MODE, 0, 0 = write INIT_VALUE to every entry; 1 = write the entry index (zero-extended or truncated to DATA_W).
INIT_VALUE, 0, constant written when INIT_MODE = 0 (DATA_W bits).
ADDR_W, $clog2(NUM_ENTRIES), address width (derived; not overridden).

Ports:
clk  in  1  clock
rstN  in  1  reset, synchronous, active-low
initStart  in  1  one-cycle pulse starting a sweep (the reset controller's reset-start output)
seqActive  in  1  high while the system reset sequence is running (the reset controller's reset output)
reqWe  in  1  normal write request
reqAddr  in  ADDR_W  normal write address
reqData  in  DATA_W  normal write data
reqReady  out  1  request accepted this cycle
ramWe  out  1  RAM write enable
ramAddr  out  ADDR_W  RAM write address
ramData  out  DATA_W  RAM write data
busy  out  1  sweep in progress
done  out  1  sweep completed (sticky)
overrun  out  1  seqActive fell before the sweep finished (sticky)

Behaviour:
- Reset
  - rstN sampled low at a clk edge: state = IDLE, counter = 0.
  - ramWe, ramAddr, ramData, busy, done, overrun all 0.
  - Reset applies mid-sweep as well: the sweep is abandoned and done stays 0.
- States: IDLE, CLEAR, DONE.
- Transitions
  - Any state, initStart = 1: go to CLEAR, counter = 0, done = 0, overrun = 0, busy = 1.
  - A pulse during CLEAR restarts the sweep from address 0.
  - CLEAR, counter = NUM_ENTRIES-1: go to DONE, busy = 0, done = 1.
  - No other transitions: DONE holds until the next initStart or reset.
- Sweep timing (all RAM outputs registered)
  - initStart sampled at edge t: ramWe = 1, ramAddr = 0 in the cycle after edge t.
  - Address k is written in the cycle after edge t+k.
  - Last write is address NUM_ENTRIES-1.
  - busy falls and done rises in the cycle after edge t+NUM_ENTRIES.
  - Exactly NUM_ENTRIES consecutive writes, no gaps, no repeats.
- Data during the sweep: INIT_VALUE (INIT_MODE = 0), or the index k zero-extended/truncated to DATA_W (INIT_MODE = 1).
- Counter
  - ADDR_W+1 bits; never wraps past NUM_ENTRIES-1.
  - Non-power-of-two NUM_ENTRIES: addresses >= NUM_ENTRIES are never driven.
- reqReady is combinational: 1 iff state != CLEAR and initStart = 0.
- Pass-through
  - When reqReady = 1 and reqWe = 1: ramWe, ramAddr, ramData = reqWe, reqAddr, reqData one cycle later.
  - When reqReady = 1 and reqWe = 0: ramWe = 0 the next cycle.
  - Requests with reqReady = 0 are not captured; the requester holds them.
- Simultaneous events
  - initStart and reqWe in the same cycle: initStart wins, the request is not accepted.
  - A sweep write always has priority; normal and sweep writes never appear in the same cycle.
- Overrun
  - Set when seqActive is sampled 0 while in CLEAR.
  - The sweep still runs to completion.
  - Cleared only by initStart or reset.
  - Never set in IDLE or DONE.
- Before the first initStart after reset (IDLE), pass-through is active and done = 0.

Test Plan:
- NUM_ENTRIES = 8, INIT_MODE = 0, INIT_VALUE = 0xA5; rstN low 2 cycles, then initStart at edge 5, seqActive = 1 throughout -> ramWe = 1 with addr 0..7, data 0xA5, in the cycles after edges 5..12; done = 1 and busy = 0 from the cycle after edge 13; overrun = 0.
- INIT_MODE = 1, NUM_ENTRIES = 6, DATA_W = 8 -> data 0x00..0x05 at addr 0..5; addr 6 and 7 are never driven; done rises after 6 writes.
- During the sweep, hold reqWe = 1, addr = 3, data = 0x7E -> reqReady = 0 throughout CLEAR. First cycle in DONE: reqReady = 1. The next cycle: ramWe = 1, addr 3, data 0x7E, exactly once per accepted cycle.
- Second initStart while counter = 4 -> the cycle after it writes addr 0; 8 further writes; done asserts only after addr 7.
- seqActive drops while counter = 2 -> overrun = 1 from the next cycle; addr 3..7 are still written; done = 1, overrun stays 1 until the next initStart.
- rstN low while counter = 5 -> next cycle: ramWe = 0, busy = 0, done = 0, overrun = 0, state IDLE; reqReady = 1.

Source files
------------

// File: rtl/ram_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ram_init_sequencer
// Description : Sweeps an initial pattern into every RAM entry after reset
//               start, then forwards normal write requests to the same port.
// Revision    : 1.0
// ============================================================================
module ram_init_sequencer #(
    parameter int                NUM_ENTRIES = 64,
    parameter int                DATA_W      = 8,
    parameter int                INIT_MODE   = 0,
    parameter logic [DATA_W-1:0] INIT_VALUE  = '0,
    parameter int                ADDR_W      = $clog2(NUM_ENTRIES)
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              initStart,
    input  logic              seqActive,
    input  logic              reqWe,
    input  logic [ADDR_W-1:0] reqAddr,
    input  logic [DATA_W-1:0] reqData,
    output logic              reqReady,
    output logic              ramWe,
    output logic [ADDR_W-1:0] ramAddr,
    output logic [DATA_W-1:0] ramData,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NUM_ENTRIES - 1);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_data_q, ram_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;
    logic                req_ready;

    // Index pattern is the entry index zero-extended or truncated to DATA_W.
    function automatic logic [DATA_W-1:0] sweep_pattern(input logic [ADDR_W-1:0] idx);
        logic [DATA_W+ADDR_W-1:0] wide;
        wide = {{DATA_W{1'b0}}, idx};
        if (INIT_MODE == 0) begin
            return INIT_VALUE;
        end
        return wide[DATA_W-1:0];
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        busy_d     = busy_q;
        done_d     = done_q;
        overrun_d  = overrun_q;
        req_ready  = (state_q != CLEAR) && !initStart;

        if (initStart) begin
            state_d    = CLEAR;
            cnt_d      = '0;
            ram_we_d   = 1'b1;
            ram_addr_d = '0;
            ram_data_d = sweep_pattern('0);
            busy_d     = 1'b1;
            done_d     = 1'b0;
            overrun_d  = 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (!seqActive) begin
                        overrun_d = 1'b1;
                    end
                    // cnt_q tracks the address currently on the RAM port.
                    if (cnt_q == LAST_IDX) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d      = cnt_q + 1'b1;
                        ram_we_d   = 1'b1;
                        ram_addr_d = cnt_d[ADDR_W-1:0];
                        ram_data_d = sweep_pattern(cnt_d[ADDR_W-1:0]);
                    end
                end
                default: begin
                    if (reqWe) begin
                        ram_we_d   = 1'b1;
                        ram_addr_d = reqAddr;
                        ram_data_d = reqData;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

    assign reqReady = req_ready;
    assign ramWe    = ram_we_q;
    assign ramAddr  = ram_addr_q;
    assign ramData  = ram_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overrun  = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_init_sequencer
// Description : Directed self-checking bench; constant-pattern instance (8
//               entries) and index-pattern instance (6 entries) share stimulus.
// Revision    : 1.0
// ============================================================================
module tb_ram_init_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       init_start;
    logic       seq_active;
    logic       req_we;
    logic [2:0] req_addr;
    logic [7:0] req_data;

    logic       a_ready, a_we, a_busy, a_done, a_ovr;
    logic [2:0] a_addr;
    logic [7:0] a_data;
    logic       b_ready, b_we, b_busy, b_done, b_ovr;
    logic [2:0] b_addr;
    logic [7:0] b_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_init_sequencer #(
        .NUM_ENTRIES(8), .DATA_W(8), .INIT_MODE(0), .INIT_VALUE(8'hA5)
    ) dut_a (
        .clk(clk), .rstN(rst_n), .initStart(init_start), .seqActive(seq_active),
        .reqWe(req_we), .reqAddr(req_addr), .reqData(req_data),
        .reqReady(a_ready), .ramWe(a_we), .ramAddr(a_addr), .ramData(a_data),
        .busy(a_busy), .done(a_done), .overrun(a_ovr)
    );

    ram_init_sequencer #(
        .NUM_ENTRIES(6), .DATA_W(8), .INIT_MODE(1), .INIT_VALUE(8'h00)
    ) dut_b (
        .clk(clk), .rstN(rst_n), .initStart(init_start), .seqActive(seq_active),
        .reqWe(req_we), .reqAddr(req_addr), .reqData(req_data),
        .reqReady(b_ready), .ramWe(b_we), .ramAddr(b_addr), .ramData(b_data),
        .busy(b_busy), .done(b_done), .overrun(b_ovr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_sweep_a(input string tag, input int k);
        chk({tag, " we"},    32'(a_we),    32'd1);
        chk({tag, " addr"},  32'(a_addr),  32'(k));
        chk({tag, " data"},  32'(a_data),  32'hA5);
        chk({tag, " busy"},  32'(a_busy),  32'd1);
        chk({tag, " done"},  32'(a_done),  32'd0);
        chk({tag, " ready"}, 32'(a_ready), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; init_start = 1'b0; seq_active = 1'b1;
        req_we = 1'b0; req_addr = 3'd0; req_data = 8'd0;
        tick(); tick();
        chk("rst we",   32'(a_we),   32'd0);
        chk("rst addr", 32'(a_addr), 32'd0);
        chk("rst data", 32'(a_data), 32'd0);
        chk("rst busy", 32'(a_busy), 32'd0);
        chk("rst done", 32'(a_done), 32'd0);
        chk("rst ovr",  32'(a_ovr),  32'd0);

        // Pass-through is live in IDLE before the first sweep.
        rst_n = 1'b1;
        tick();
        chk("idle ready", 32'(a_ready), 32'd1);
        chk("idle done",  32'(a_done),  32'd0);
        req_we = 1'b1; req_addr = 3'd2; req_data = 8'h33;
        tick();
        chk("idle pt we",   32'(a_we),   32'd1);
        chk("idle pt addr", 32'(a_addr), 32'd2);
        chk("idle pt data", 32'(a_data), 32'h33);
        req_we = 1'b0;
        tick();
        chk("idle pt idle we", 32'(a_we), 32'd0);

        // Sweep 1 with a request held for the whole sweep.
        init_start = 1'b1;
        #1;
        chk("start ready", 32'(a_ready), 32'd0);
        tick();
        init_start = 1'b0;
        req_we = 1'b1; req_addr = 3'd3; req_data = 8'h7E;
        for (int k = 0; k < 8; k++) begin
            chk_sweep_a("s1", k);
            chk("s1 ovr", 32'(a_ovr), 32'd0);
            if (k < 6) begin
                chk("b we",   32'(b_we),   32'd1);
                chk("b addr", 32'(b_addr), 32'(k));
                chk("b data", 32'(b_data), 32'(k));
            end else if (k == 6) begin
                chk("b end we",   32'(b_we),   32'd0);
                chk("b end done", 32'(b_done), 32'd1);
                chk("b end busy", 32'(b_busy), 32'd0);
            end
            tick();
        end
        chk("s1 done",  32'(a_done),  32'd1);
        chk("s1 busy",  32'(a_busy),  32'd0);
        chk("s1 we",    32'(a_we),    32'd0);
        chk("s1 ovr",   32'(a_ovr),   32'd0);
        chk("s1 ready", 32'(a_ready), 32'd1);
        tick();
        chk("held pt we",   32'(a_we),   32'd1);
        chk("held pt addr", 32'(a_addr), 32'd3);
        chk("held pt data", 32'(a_data), 32'h7E);
        req_we = 1'b0;
        tick();
        chk("held pt off", 32'(a_we), 32'd0);

        // Sweep 2, restarted while counter = 4; initStart beats a request.
        init_start = 1'b1; req_we = 1'b1; req_addr = 3'd6; req_data = 8'h11;
        tick();
        init_start = 1'b0; req_we = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk_sweep_a("s2a", k);
            if (k < 4) tick();
        end
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk_sweep_a("s2b", k);
            tick();
        end
        chk("s2 done", 32'(a_done), 32'd1);
        chk("s2 busy", 32'(a_busy), 32'd0);

        // Sweep 3, seqActive drops while counter = 2.
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk_sweep_a("s3", k);
            chk("s3 ovr", 32'(a_ovr), (k >= 3) ? 32'd1 : 32'd0);
            if (k == 2) seq_active = 1'b0;
            tick();
        end
        chk("s3 done", 32'(a_done), 32'd1);
        chk("s3 ovr",  32'(a_ovr),  32'd1);
        tick();
        chk("s3 ovr sticky", 32'(a_ovr), 32'd1);
        seq_active = 1'b1;
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        chk("s4 ovr clr", 32'(a_ovr), 32'd0);

        // Sweep 4 interrupted by reset while counter = 5.
        for (int k = 0; k < 6; k++) begin
            chk_sweep_a("s4", k);
            if (k < 5) tick();
        end
        rst_n = 1'b0;
        tick();
        chk("mid rst we",    32'(a_we),    32'd0);
        chk("mid rst busy",  32'(a_busy),  32'd0);
        chk("mid rst done",  32'(a_done),  32'd0);
        chk("mid rst ovr",   32'(a_ovr),   32'd0);
        chk("mid rst ready", 32'(a_ready), 32'd1);
        rst_n = 1'b1;
        tick();
        chk("post rst done", 32'(a_done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
